// File: rtl/ssc_tx.sv
// Spread-spectrum test-signal transmitter: carrier DDS + quarter-wave sine,
// BPSK-spread by a chip DDS driving a configurable Galois LFSR.
// Accepted tick in cycle N gives pushDAC/DAC in cycle N+2; full rate, no stall.
`timescale 1ns/1ps

// Quarter-wave sine lookup, v spans 0..pi/2. Output is v*(2^(AW+1)-v) scaled
// so the top entry lands exactly on 0x7FFF (parabolic fit, never exceeds 0x7FFF).
module sine #(
  parameter int AW = 13
) (
  input  logic [AW-1:0] v,
  output logic [15:0]   sv
);
  localparam logic [AW+1:0] FULL = {2'b10, {AW{1'b0}}};

  logic [AW+1:0]   comp;
  logic [2*AW+1:0] prod;
  logic            unused_prod;

  assign comp        = FULL - {2'b00, v};
  assign prod        = {{(AW+2){1'b0}}, v} * {{AW{1'b0}}, comp};
  assign sv          = prod[2*AW -: 16];
  assign unused_prod = ^{prod[2*AW+1], prod[2*AW-16:0]};
endmodule

module ssc_tx #(
  parameter logic [15:0] BASE_ADDR = 16'h0900,
  parameter int          SINE_AW   = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic        tick,
  output logic [15:0] DAC,
  output logic        pushDAC,
  output logic        epoch,
  output logic        irq
);
  // register file
  logic        run;
  logic [31:0] carr_add, carr_phase, chip_freq, chip_phase;
  logic [3:0]  prn_hob;
  logic [13:0] prn_poly, prn_state;
  logic [3:0]  amp_shift;
  logic [31:0] sample_count, epoch_count;
  logic        epoch_flag;
  logic        status_rd_d;

  // address decode on the low half only
  logic [15:0] a16;
  logic        unused_addr;
  logic sel_run, sel_cadd, sel_cph, sel_cfreq, sel_chph;
  logic sel_prn, sel_amp, sel_scnt, sel_ecnt, sel_status;

  assign a16         = addr[15:0];
  assign unused_addr = ^addr[31:16];
  assign sel_run     = (a16 == BASE_ADDR + 16'h0000);
  assign sel_cadd    = (a16 == BASE_ADDR + 16'h0004);
  assign sel_cph     = (a16 == BASE_ADDR + 16'h0008);
  assign sel_cfreq   = (a16 == BASE_ADDR + 16'h000C);
  assign sel_chph    = (a16 == BASE_ADDR + 16'h0010);
  assign sel_prn     = (a16 == BASE_ADDR + 16'h0014);
  assign sel_amp     = (a16 == BASE_ADDR + 16'h0018);
  assign sel_scnt    = (a16 == BASE_ADDR + 16'h001C);
  assign sel_ecnt    = (a16 == BASE_ADDR + 16'h0020);
  assign sel_status  = (a16 == BASE_ADDR + 16'h0024);

  // stage 0: fold the carrier phase into one quadrant of the table
  logic               acc;
  logic [1:0]         quad;
  logic [SINE_AW-1:0] sine_addr;
  logic [15:0]        sine_val;
  logic               chip_bit;

  assign acc       = tick & run;
  assign quad      = carr_phase[31:30];
  assign sine_addr = quad[0] ? ~carr_phase[29 -: SINE_AW] : carr_phase[29 -: SINE_AW];
  assign chip_bit  = prn_state[prn_hob];

  sine #(.AW(SINE_AW)) u_sine (
    .v  (sine_addr),
    .sv (sine_val)
  );

  // PRN advances on each rising edge of the chip clock (CHIP_PHASE[31])
  logic [31:0] chip_next;
  logic [13:0] lfsr_cleared, lfsr_next;
  logic        prn_step, epoch_hit, status_rd_first;

  assign chip_next       = chip_phase + chip_freq;
  assign prn_step        = acc & ~chip_phase[31] & chip_next[31];
  assign epoch_hit       = prn_step & (lfsr_next == 14'h0001);
  assign status_rd_first = read & sel_status & ~status_rd_d;

  // Galois step: drop the output bit, shift, fold the polynomial back in
  always_comb begin
    lfsr_cleared          = prn_state;
    lfsr_cleared[prn_hob] = 1'b0;
    lfsr_next             = {lfsr_cleared[12:0], 1'b0} ^ (chip_bit ? prn_poly : 14'h0000);
  end

  // registers: tick-driven updates first, a same-cycle bus write overrides them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run          <= 1'b0;
      carr_add     <= '0;
      carr_phase   <= '0;
      chip_freq    <= '0;
      chip_phase   <= '0;
      prn_hob      <= '0;
      prn_poly     <= '0;
      prn_state    <= '0;
      amp_shift    <= '0;
      sample_count <= '0;
      epoch_count  <= '0;
      epoch_flag   <= 1'b0;
      status_rd_d  <= 1'b0;
      epoch        <= 1'b0;
    end else begin
      if (acc) begin
        carr_phase   <= carr_phase + carr_add;
        chip_phase   <= chip_next;
        sample_count <= sample_count + 32'd1;
      end
      if (prn_step)        prn_state   <= lfsr_next;
      if (epoch_hit)       epoch_count <= epoch_count + 32'd1;
      if (status_rd_first) epoch_flag  <= 1'b0;
      if (epoch_hit)       epoch_flag  <= 1'b1;
      if (write) begin
        if (sel_run)    run          <= Wdata[0];
        if (sel_cadd)   carr_add     <= Wdata;
        if (sel_cph)    carr_phase   <= Wdata;
        if (sel_cfreq)  chip_freq    <= Wdata;
        if (sel_chph)   chip_phase   <= Wdata;
        if (sel_prn)    {prn_hob, prn_poly, prn_state} <= Wdata;
        if (sel_amp)    amp_shift    <= Wdata[3:0];
        if (sel_scnt)   sample_count <= Wdata;
        if (sel_ecnt)   epoch_count  <= Wdata;
        if (sel_status) epoch_flag   <= Wdata[0];
      end
      status_rd_d <= read & sel_status;
      epoch       <= epoch_hit;
    end
  end

  assign irq = epoch_flag;

  // stage 1: BPSK sign (carrier half-cycle XOR chip) then amplitude shift
  logic        s1_vld, s1_neg;
  logic [15:0] s1_sv;
  logic signed [15:0] s1_signed, s1_shifted;

  assign s1_signed  = s1_neg ? -$signed(s1_sv) : $signed(s1_sv);
  assign s1_shifted = s1_signed >>> amp_shift;

  // sample pipeline: stage-0 capture, then DAC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_neg  <= 1'b0;
      s1_sv   <= '0;
      pushDAC <= 1'b0;
      DAC     <= '0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        s1_sv  <= sine_val;
        s1_neg <= quad[1] ^ chip_bit;
      end
      pushDAC <= s1_vld;
      if (s1_vld) DAC <= s1_shifted;
    end
  end

  // combinational read mux; zero unless reading a mapped register
  always_comb begin
    Rdata = '0;
    if (read) begin
      if (sel_run)    Rdata = {31'b0, run};
      if (sel_cadd)   Rdata = carr_add;
      if (sel_cph)    Rdata = carr_phase;
      if (sel_cfreq)  Rdata = chip_freq;
      if (sel_chph)   Rdata = chip_phase;
      if (sel_prn)    Rdata = {prn_hob, prn_poly, prn_state};
      if (sel_amp)    Rdata = {28'b0, amp_shift};
      if (sel_scnt)   Rdata = sample_count;
      if (sel_ecnt)   Rdata = epoch_count;
      if (sel_status) Rdata = {30'b0, run, epoch_flag};
    end
  end
endmodule
